spi_sclk_gen: RTL and testbench



---
 rtl/spi_sclk_gen.sv | 65 ++++++
 tb/tb_spi_sclk_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SPI SCLK divider gated by chip-select, plus rise/fall strobes on the SCLK pad.
// Define SCLK_SYNC_EN to put a two-flop synchroniser in front of the edge detector.
module spi_sclk_gen #(
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] divider,
    input  logic       cpol,
    input  logic       cs,
    output logic       sclk,
    input  logic       sig,
    output logic       sclk_pe,
    output logic       sclk_ne
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_lim;
    logic             r_sclk;
    logic             r_h;
    logic             r_v;
    logic             w_cur;

    assign w_lim = (CNT_W'(1) << divider) - CNT_W'(1);
    assign sclk  = r_sclk;

    // >= rather than == so a divider lowered mid-run toggles immediately instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (cs) begin
            r_cnt  <= '0;
            r_sclk <= cpol;
        end else if (r_cnt >= w_lim) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

`ifdef SCLK_SYNC_EN
    logic [1:0] r_sync;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '0;
        else      r_sync <= {r_sync[0], sig};
    end
    assign w_cur = r_sync[1];
`else
    assign w_cur = sig;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h <= 1'b0;
            r_v <= 1'b0;
        end else begin
            r_h <= w_cur;
            r_v <= 1'b1;
        end
    end

    assign sclk_pe = r_v & w_cur & ~r_h;
    assign sclk_ne = r_v & ~w_cur & r_h;
endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: directed and randomized checks of spi_sclk_gen against a rule-level model.
module tb_spi_sclk_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] divider = 3'd0;
    logic       cpol = 1'b0;
    logic       cs = 1'b1;
    logic       sig_r = 1'b0;
    logic       loop = 1'b0;
    logic       sig_w;
    logic       sclk, sclk_pe, sclk_ne;

    int n_total = 0, n_pass = 0, n_fail = 0;
    // model: sig sampled at the last three edges, edges since reset release, active-run bookkeeping
    logic e0 = 0, e1 = 0, e2 = 0;
    int   n_edges = 0;
    logic m_base = 0, m_sclk = 0;
    int   m_j = 0;
    int   npe = 0, nne = 0, alt_err = 0;
    int   last = -1;

    assign sig_w = loop ? sclk : sig_r;

    spi_sclk_gen dut (
        .clk(clk), .rst(rst), .divider(divider), .cpol(cpol), .cs(cs),
        .sclk(sclk), .sig(sig_w), .sclk_pe(sclk_pe), .sclk_ne(sclk_ne)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic cur_m();
`ifdef SCLK_SYNC_EN
        return e1;
`else
        return sig_w;
`endif
    endfunction

    function automatic logic h_m();
`ifdef SCLK_SYNC_EN
        return e2;
`else
        return e0;
`endif
    endfunction

    function automatic logic exp_pe();
        return (n_edges >= 1) && cur_m() && !h_m();
    endfunction

    function automatic logic exp_ne();
        return (n_edges >= 1) && !cur_m() && h_m();
    endfunction

    task automatic cyc(input logic ncs, input logic nsig);
        logic pre;
        cs = ncs;
        sig_r = nsig;
        #1;
        chk("pe_pre", sclk_pe, exp_pe());
        chk("ne_pre", sclk_ne, exp_ne());
        pre = sig_w;
        @(posedge clk);
        e2 = e1; e1 = e0; e0 = pre;
        n_edges++;
        if (ncs) begin
            m_base = cpol; m_j = 0; m_sclk = cpol;
        end else begin
            m_j++;
            m_sclk = m_base ^ 1'((m_j >> divider) & 1);
        end
        #1;
        chk("sclk", sclk, m_sclk);
        chk("pe", sclk_pe, exp_pe());
        chk("ne", sclk_ne, exp_ne());
        if (sclk_pe) begin
            if (last == 1) alt_err++;
            last = 1; npe++;
        end
        if (sclk_ne) begin
            if (last == 0) alt_err++;
            last = 0; nne++;
        end
    endtask

    task automatic do_reset(input logic pol);
        rst = 1'b0;
        #1;
        chk("rst_sclk", sclk, 0);
        chk("rst_pe", sclk_pe, 0);
        chk("rst_ne", sclk_ne, 0);
        e0 = 0; e1 = 0; e2 = 0; n_edges = 0;
        m_sclk = 0; m_base = 0; m_j = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold", sclk, 0);
        cs = 1'b1;
        cpol = pol;
        rst = 1'b1;
    endtask

    initial begin
        do_reset(1'b0);
        // divider 0: toggle every clock
        divider = 3'd0; cpol = 1'b0;
        repeat (2) cyc(1'b1, 1'b0);
        repeat (8) cyc(1'b0, 1'($urandom_range(0, 1)));
        // divider 2: 4 high / 4 low
        divider = 3'd2;
        cyc(1'b1, 1'b1);
        repeat (20) cyc(1'b0, 1'($urandom_range(0, 1)));
        // cpol 1, divider 1, abort mid half-period, then restart from cnt 0
        divider = 3'd1; cpol = 1'b1;
        repeat (2) cyc(1'b1, 1'b0);
        repeat (13) cyc(1'b0, 1'($urandom_range(0, 1)));
        cyc(1'b1, 1'b0);
        chk("abort_level", sclk, 1);
        repeat (4) cyc(1'b0, 1'b1);
        // divider lowered from 7 to 0 with cnt at 100
        divider = 3'd7; cpol = 1'b0;
        repeat (2) cyc(1'b1, 1'b0);
        repeat (100) cyc(1'b0, 1'b0);
        divider = 3'd0;
        m_base = m_sclk; m_j = 0;
        cyc(1'b0, 1'b0);
        chk("no_stall", sclk, 1);
        repeat (3) cyc(1'b0, 1'b1);
        // reset mid-run with pad high, release idle with cpol 1
        sig_r = 1'b1;
        do_reset(1'b1);
        repeat (4) cyc(1'b1, 1'b1);
        // loopback: 16 half-periods at divider 1
        divider = 3'd1; cpol = 1'b0;
        repeat (3) cyc(1'b1, 1'b0);
        loop = 1'b1;
        repeat (2) cyc(1'b1, 1'b0);
        npe = 0; nne = 0; alt_err = 0; last = -1;
        repeat (32) cyc(1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0);
        chk("loop_pe", npe, 8);
        chk("loop_ne", nne, 8);
        chk("loop_alt", alt_err, 0);
        loop = 1'b0;
        // randomized segments
        for (int s = 0; s < 12; s++) begin
            divider = 3'($urandom_range(0, 7));
            cpol = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 4)) cyc(1'b1, 1'($urandom_range(0, 1)));
            for (int i = 0; i < int'($urandom_range(1, 6 << divider)); i++) begin
                if ($urandom_range(0, 15) == 0) cpol = ~cpol;
                cyc(1'b0, 1'($urandom_range(0, 1)));
            end
        end
        cyc(1'b1, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
